pong_engine: RTL and testbench

Game-logic bus master for the Pong arcade design. On each frame tick it updates both paddle positions from player buttons, advances the ball, resolves wall and paddle bounces and misses, then writes the four object positions to the VGA display's position registers over the `sel`/`addr`/`data_out` write bus. It sits between the button inputs and the display block; it is the writer side of the display's position-register interface.

---
 rtl/pong_engine_if.sv | 13 +
 rtl/pong_engine.sv | 237 +++++++++++++++++++++++
 tb/tb_pong_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_engine_if.sv
// Position-register write bus between the Pong game engine and the VGA display.
//   sel      : write strobe, one cycle per register write
//   addr     : 00 ball_x, 01 ball_y, 10 paddle_1, 11 paddle_2
//   data_out : write data, 9-bit fields zero-extended
// master = engine (writer), slave = display (position registers).
interface pong_engine_if;
  logic       sel;
  logic [1:0] addr;
  logic [9:0] data_out;

  modport master (output sel, addr, data_out);
  modport slave  (input  sel, addr, data_out);
endinterface

// File: rtl/pong_engine.sv
// pong_engine: per-frame game logic for Pong, bus master toward the display.
// On each accepted frame_tick: move paddles, step ball, resolve wall/paddle
// bounces and misses, then write ball_x, ball_y, paddle_1, paddle_2 to the
// display over bus (sel/addr/data_out), one register per cycle.
// Ports:
//   clk                  system clock
//   rst                  asynchronous active-low reset
//   frame_tick           one-cycle pulse per frame; ignored unless idle
//   btn_up1/btn_dn1      player 1 paddle buttons (sampled in PADDLE only)
//   btn_up2/btn_dn2      player 2 paddle buttons (sampled in PADDLE only)
//   bus                  position-register write bus (master side)
//   busy                 high from the cycle after a tick to the last write
//   score1/score2        player scores, saturating at 9
// Build option: define PONG_SCORE_EN to build the score counters; without it
// the score outputs are tied to zero.
module pong_engine #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                btn_up1,
  input  logic                btn_dn1,
  input  logic                btn_up2,
  input  logic                btn_dn2,
  pong_engine_if.master       bus,
  output logic                busy,
  output logic [3:0]          score1,
  output logic [3:0]          score2
);

  // Geometry (x vertical, y horizontal), all in 11-bit signed space
  localparam logic signed [10:0] BALL_SZ = 11'sd10;
  localparam logic signed [10:0] PAD_LEN = 11'sd40;
  localparam logic signed [10:0] X_MIN   = 11'sd10;
  localparam logic signed [10:0] X_MAX   = 11'(HEIGHT - 20);
  localparam logic signed [10:0] Y_MIN   = 11'sd10;
  localparam logic signed [10:0] Y_MAX   = 11'(WIDTH - 20);
  localparam logic signed [10:0] P1_HIT  = 11'sd40;             // paddle 1 column 30 + width 10
  localparam logic signed [10:0] P2_HIT  = 11'(WIDTH - 50);     // paddle 2 column (WIDTH-40) - ball 10
  localparam logic signed [10:0] PAD_MIN = 11'sd10;
  localparam logic signed [10:0] PAD_MAX = 11'(HEIGHT - 50);
  localparam logic signed [10:0] CX      = 11'((HEIGHT - 10) / 2);
  localparam logic signed [10:0] CY      = 11'((WIDTH - 10) / 2);
  localparam logic [8:0]         PAD_RST = 9'((HEIGHT - 40) / 2);
  localparam logic signed [10:0] BSTEP   = 11'(BALL_SPEED);
  localparam logic signed [10:0] PSTEP   = 11'(PADDLE_SPEED);

  typedef enum logic [2:0] {
    S_IDLE, S_PADDLE, S_BALL, S_COLLIDE, S_WR0, S_WR1, S_WR2, S_WR3
  } state_t;

  state_t             state_q, state_d;
  logic signed [10:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic               dx_q, dx_d, dy_q, dy_d;
  logic [8:0]         pad1_q, pad1_d, pad2_q, pad2_d;
  logic               sel_q, sel_d, busy_q, busy_d;
  logic [1:0]         addr_q, addr_d;
  logic [9:0]         data_q, data_d;

  // Collision working values
  logic signed [10:0] bx, by;
  logic               hit1, hit2;

`ifdef PONG_SCORE_EN
  logic [3:0] score1_q, score1_d, score2_q, score2_d;
  assign score1 = score1_q;
  assign score2 = score2_q;
`else
  assign score1 = '0;
  assign score2 = '0;
`endif

  assign bus.sel      = sel_q;
  assign bus.addr     = addr_q;
  assign bus.data_out = data_q;
  assign busy         = busy_q;

  function automatic logic [8:0] step_pad(input logic [8:0] p, input logic up, input logic dn);
    logic signed [10:0] t;
    t = signed'({2'b00, p});
    if (up && !dn)      t = t - PSTEP;
    else if (dn && !up) t = t + PSTEP;
    if (t < PAD_MIN)      t = PAD_MIN;
    else if (t > PAD_MAX) t = PAD_MAX;
    return t[8:0];
  endfunction

  function automatic logic overlaps(input logic signed [10:0] x, input logic [8:0] p);
    logic signed [10:0] ps;
    ps = signed'({2'b00, p});
    return ((x + BALL_SZ) > ps) && (x < (ps + PAD_LEN));
  endfunction

  always_comb begin
    state_d  = state_q;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    pad1_d   = pad1_q;
    pad2_d   = pad2_q;
    sel_d    = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    busy_d   = busy_q;
    bx       = ball_x_q;
    by       = ball_y_q;
    hit1     = 1'b0;
    hit2     = 1'b0;
`ifdef PONG_SCORE_EN
    score1_d = score1_q;
    score2_d = score2_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d = S_PADDLE;
          busy_d  = 1'b1;
        end
      end
      S_PADDLE: begin
        pad1_d  = step_pad(pad1_q, btn_up1, btn_dn1);
        pad2_d  = step_pad(pad2_q, btn_up2, btn_dn2);
        state_d = S_BALL;
      end
      S_BALL: begin
        ball_x_d = dx_q ? ball_x_q + BSTEP : ball_x_q - BSTEP;
        ball_y_d = dy_q ? ball_y_q + BSTEP : ball_y_q - BSTEP;
        state_d  = S_COLLIDE;
      end
      S_COLLIDE: begin
        // Walls first; paddle checks then see the clamped x. A paddle hit
        // takes priority over a miss on the same frame.
        if (bx <= X_MIN) begin
          bx   = X_MIN;
          dx_d = 1'b1;
        end else if (bx >= X_MAX) begin
          bx   = X_MAX;
          dx_d = 1'b0;
        end
        hit1 = (by <= P1_HIT) && !dy_q && overlaps(bx, pad1_q);
        hit2 = (by >= P2_HIT) &&  dy_q && overlaps(bx, pad2_q);
        if (hit1) begin
          by   = P1_HIT;
          dy_d = 1'b1;
        end else if (hit2) begin
          by   = P2_HIT;
          dy_d = 1'b0;
        end else if (by <= Y_MIN) begin
          bx   = CX;
          by   = CY;
          dy_d = 1'b0;
`ifdef PONG_SCORE_EN
          if (score2_q != 4'd9) score2_d = score2_q + 4'd1;
`endif
        end else if (by >= Y_MAX) begin
          bx   = CX;
          by   = CY;
          dy_d = 1'b1;
`ifdef PONG_SCORE_EN
          if (score1_q != 4'd9) score1_d = score1_q + 4'd1;
`endif
        end
        ball_x_d = bx;
        ball_y_d = by;
        sel_d    = 1'b1;
        addr_d   = 2'd0;
        data_d   = bx[9:0];
        state_d  = S_WR0;
      end
      S_WR0: begin
        sel_d   = 1'b1;
        addr_d  = 2'd1;
        data_d  = ball_y_q[9:0];
        state_d = S_WR1;
      end
      S_WR1: begin
        sel_d   = 1'b1;
        addr_d  = 2'd2;
        data_d  = {1'b0, pad1_q};
        state_d = S_WR2;
      end
      S_WR2: begin
        sel_d   = 1'b1;
        addr_d  = 2'd3;
        data_d  = {1'b0, pad2_q};
        state_d = S_WR3;
      end
      S_WR3: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ball_x_q <= CX;
      ball_y_q <= CY;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      pad1_q   <= PAD_RST;
      pad2_q   <= PAD_RST;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
`ifdef PONG_SCORE_EN
      score1_q <= '0;
      score2_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ball_x_q <= ball_x_d;
      ball_y_q <= ball_y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      pad1_q   <= pad1_d;
      pad2_q   <= pad2_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
`ifdef PONG_SCORE_EN
      score1_q <= score1_d;
      score2_q <= score2_d;
`endif
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: reset state, first-frame write timing,
// paddle movement and clamping, paddle-2 bounce, walls, right misses with
// score saturation, ignored mid-sequence ticks and mid-sequence reset.
module tb_pong_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_up1 = 1'b0, btn_dn1 = 1'b0, btn_up2 = 1'b0, btn_dn2 = 1'b0;
  logic       busy;
  logic [3:0] score1, score2;

  pong_engine_if bus ();

  pong_engine #(
    .WIDTH(640), .HEIGHT(480), .BALL_SPEED(2), .PADDLE_SPEED(4)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_up1(btn_up1), .btn_dn1(btn_dn1), .btn_up2(btn_up2), .btn_dn2(btn_dn2),
    .bus(bus), .busy(busy), .score1(score1), .score2(score2)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miscmp = 0;

  // Writes captured by run_frame, in order of appearance
  logic [1:0] wr_addr [0:7];
  logic [9:0] wr_data [0:7];
  int         wr_n;
  int         first_wr;
  logic       busy_seen [0:11];

  task automatic apply_reset();
    btn_up1 = 0; btn_dn1 = 0; btn_up2 = 0; btn_dn2 = 0; frame_tick = 0;
    @(negedge clk) rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
  endtask

  // Called at a negedge with the engine idle; tick is sampled at the next
  // posedge (T). Observes cycles T+1..T+10 at their negedges.
  task automatic run_frame(input bit extra_tick);
    wr_n = 0;
    first_wr = 0;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    for (int c = 1; c <= 10; c++) begin
      busy_seen[c] = busy;
      if (bus.sel) begin
        if (wr_n == 0) first_wr = c;
        if (wr_n < 8) begin
          wr_addr[wr_n] = bus.addr;
          wr_data[wr_n] = bus.data_out;
        end
        wr_n++;
      end
      frame_tick = extra_tick && (c == 1);
      @(negedge clk);
    end
    frame_tick = 0;
  endtask

  task automatic test_reset();
    int sel_cnt;
    btn_up1 = 0; btn_dn1 = 0; btn_up2 = 0; btn_dn2 = 0;
    @(negedge clk) rst = 0;
    #1;
    vec++; if (bus.sel !== 1'b0) begin miscmp++; $display("FAIL reset_sel got %b exp 0", bus.sel); end
    vec++; if (bus.addr !== 2'b00) begin miscmp++; $display("FAIL reset_addr got %b exp 00", bus.addr); end
    vec++; if (bus.data_out !== 10'd0) begin miscmp++; $display("FAIL reset_data got %0d exp 0", bus.data_out); end
    vec++; if (busy !== 1'b0) begin miscmp++; $display("FAIL reset_busy got %b exp 0", busy); end
    vec++; if (score1 !== 4'd0 || score2 !== 4'd0) begin miscmp++; $display("FAIL reset_scores got %0d/%0d exp 0/0", score1, score2); end
    repeat (2) @(negedge clk);
    rst = 1;
    sel_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.sel === 1'b1 || busy === 1'b1) sel_cnt++;
    end
    vec++; if (sel_cnt !== 0) begin miscmp++; $display("FAIL idle_no_writes got %0d active cycles exp 0", sel_cnt); end
  endtask

  task automatic test_first_frame();
    apply_reset();
    run_frame(0);
    vec++; if (first_wr !== 4) begin miscmp++; $display("FAIL first_write_cycle got T+%0d exp T+4", first_wr); end
    vec++; if (wr_n !== 4) begin miscmp++; $display("FAIL first_write_count got %0d exp 4", wr_n); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (wr_addr[i] !== 2'(i)) begin miscmp++; $display("FAIL first_addr%0d got %0d exp %0d", i, wr_addr[i], i); end
    end
    vec++; if (wr_data[0] !== 10'd237) begin miscmp++; $display("FAIL first_ball_x got %0d exp 237", wr_data[0]); end
    vec++; if (wr_data[1] !== 10'd317) begin miscmp++; $display("FAIL first_ball_y got %0d exp 317", wr_data[1]); end
    vec++; if (wr_data[2] !== 10'd220) begin miscmp++; $display("FAIL first_pad1 got %0d exp 220", wr_data[2]); end
    vec++; if (wr_data[3] !== 10'd220) begin miscmp++; $display("FAIL first_pad2 got %0d exp 220", wr_data[3]); end
    vec++; if (busy_seen[1] !== 1'b1) begin miscmp++; $display("FAIL busy_T1 got %b exp 1", busy_seen[1]); end
    vec++; if (busy_seen[7] !== 1'b1) begin miscmp++; $display("FAIL busy_T7 got %b exp 1", busy_seen[7]); end
    vec++; if (busy_seen[8] !== 1'b0) begin miscmp++; $display("FAIL busy_T8 got %b exp 0", busy_seen[8]); end
  endtask

  task automatic test_paddles();
    int e1, e2;
    apply_reset();
    // Both player-1 buttons: no movement
    btn_up1 = 1; btn_dn1 = 1;
    for (int k = 1; k <= 3; k++) begin
      run_frame(0);
      vec++; if (wr_data[2] !== 10'd220) begin miscmp++; $display("FAIL pad1_both k=%0d got %0d exp 220", k, wr_data[2]); end
      vec++; if (wr_data[3] !== 10'd220) begin miscmp++; $display("FAIL pad2_none k=%0d got %0d exp 220", k, wr_data[3]); end
    end
    btn_dn1 = 0; btn_dn2 = 1;
    for (int k = 1; k <= 60; k++) begin
      run_frame(0);
      e1 = 220 - 4 * k; if (e1 < 10) e1 = 10;
      e2 = 220 + 4 * k; if (e2 > 430) e2 = 430;
      vec++; if (wr_data[2] !== 10'(e1)) begin miscmp++; $display("FAIL pad1_up k=%0d got %0d exp %0d", k, wr_data[2], e1); end
      vec++; if (wr_data[3] !== 10'(e2)) begin miscmp++; $display("FAIL pad2_dn k=%0d got %0d exp %0d", k, wr_data[3], e2); end
    end
  endtask

  task automatic test_paddle2_hit();
    apply_reset();
    for (int k = 1; k <= 139; k++) begin
      btn_dn2 = (k <= 46);
      run_frame(0);
      if (k == 46) begin
        vec++; if (wr_data[3] !== 10'd404) begin miscmp++; $display("FAIL hit_pad2_pos got %0d exp 404", wr_data[3]); end
      end
      if (k == 137) begin
        vec++; if (wr_data[0] !== 10'd412 || wr_data[1] !== 10'd589) begin miscmp++; $display("FAIL hit_pre got (%0d,%0d) exp (412,589)", wr_data[0], wr_data[1]); end
      end
      if (k == 138) begin
        vec++; if (wr_data[0] !== 10'd410 || wr_data[1] !== 10'd590) begin miscmp++; $display("FAIL hit_bounce got (%0d,%0d) exp (410,590)", wr_data[0], wr_data[1]); end
      end
      if (k == 139) begin
        vec++; if (wr_data[0] !== 10'd408 || wr_data[1] !== 10'd588) begin miscmp++; $display("FAIL hit_post got (%0d,%0d) exp (408,588)", wr_data[0], wr_data[1]); end
      end
    end
    vec++; if (score1 !== 4'd0) begin miscmp++; $display("FAIL hit_score1 got %0d exp 0", score1); end
  endtask

  // Pads stay at 220 and never meet the ball; ball misses right every 153
  // frames, alternating bottom-wall and top-wall bounces in between.
  task automatic test_miss_and_walls();
    int es;
    apply_reset();
    for (int k = 1; k <= 1530; k++) begin
      run_frame(0);
      if (k == 112 || k == 113 || k == 114) begin
        es = (k == 112) ? 459 : (k == 113) ? 460 : 458;
        vec++; if (wr_data[0] !== 10'(es)) begin miscmp++; $display("FAIL bottom_wall k=%0d got %0d exp %0d", k, wr_data[0], es); end
      end
      if (k == 152) begin
        vec++; if (wr_data[0] !== 10'd382 || wr_data[1] !== 10'd619) begin miscmp++; $display("FAIL pre_miss got (%0d,%0d) exp (382,619)", wr_data[0], wr_data[1]); end
      end
      if (k == 265 || k == 266 || k == 267) begin
        es = (k == 265) ? 11 : (k == 266) ? 10 : 12;
        vec++; if (wr_data[0] !== 10'(es)) begin miscmp++; $display("FAIL top_wall k=%0d got %0d exp %0d", k, wr_data[0], es); end
      end
      if (k == 266) begin
        vec++; if (wr_data[1] !== 10'd541) begin miscmp++; $display("FAIL top_wall_y got %0d exp 541", wr_data[1]); end
      end
      if (k % 153 == 0) begin
        vec++; if (wr_data[0] !== 10'd235 || wr_data[1] !== 10'd315) begin miscmp++; $display("FAIL miss_recentre k=%0d got (%0d,%0d) exp (235,315)", k, wr_data[0], wr_data[1]); end
        es = (k / 153 > 9) ? 9 : k / 153;
`ifndef PONG_SCORE_EN
        es = 0;
`endif
        vec++; if (score1 !== 4'(es)) begin miscmp++; $display("FAIL miss_score1 k=%0d got %0d exp %0d", k, score1, es); end
        vec++; if (score2 !== 4'd0) begin miscmp++; $display("FAIL miss_score2 k=%0d got %0d exp 0", k, score2); end
      end
    end
  endtask

  task automatic test_tick_ignored();
    apply_reset();
    run_frame(1);
    vec++; if (wr_n !== 4) begin miscmp++; $display("FAIL extra_tick_writes got %0d exp 4", wr_n); end
    vec++; if (wr_data[0] !== 10'd237 || wr_data[1] !== 10'd317) begin miscmp++; $display("FAIL extra_tick_ball got (%0d,%0d) exp (237,317)", wr_data[0], wr_data[1]); end
    run_frame(0);
    vec++; if (wr_n !== 4 || wr_data[0] !== 10'd239) begin miscmp++; $display("FAIL next_frame got n=%0d x=%0d exp n=4 x=239", wr_n, wr_data[0]); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    btn_up1 = 1;
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    repeat (4) @(negedge clk);
    vec++; if (bus.sel !== 1'b1 || bus.addr !== 2'd1) begin miscmp++; $display("FAIL mid_T5_write got sel=%b addr=%0d exp sel=1 addr=1", bus.sel, bus.addr); end
    rst = 0;
    #1;
    vec++; if (bus.sel !== 1'b0) begin miscmp++; $display("FAIL mid_reset_sel got %b exp 0", bus.sel); end
    vec++; if (busy !== 1'b0 || bus.addr !== 2'b00 || bus.data_out !== 10'd0) begin miscmp++; $display("FAIL mid_reset_outs got busy=%b addr=%0d data=%0d exp 0/0/0", busy, bus.addr, bus.data_out); end
    @(negedge clk);
    btn_up1 = 0;
    rst = 1;
    @(negedge clk);
    run_frame(0);
    vec++; if (wr_n !== 4) begin miscmp++; $display("FAIL after_reset_writes got %0d exp 4", wr_n); end
    vec++; if (wr_data[0] !== 10'd237 || wr_data[1] !== 10'd317 || wr_data[2] !== 10'd220 || wr_data[3] !== 10'd220)
      begin miscmp++; $display("FAIL after_reset_pos got (%0d,%0d,%0d,%0d) exp (237,317,220,220)", wr_data[0], wr_data[1], wr_data[2], wr_data[3]); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_paddles();
    test_paddle2_hit();
    test_miss_and_walls();
    test_tick_ignored();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  // Hard stop in case the sequence above stalls
  initial begin
    #2000000;
    $display("FAIL timeout got no completion exp completion");
    $fatal(1, "timeout");
  end

endmodule
